frame_writer: RTL and testbench
===============================

Name: frame_writer

Overview:
Sequential byte-writer that fills the 640x480 8-bit image store. It is the write-side counterpart of the multi-port image ROM. It accepts a stream of 16-bit processed pixel words over a valid/ready handshake and splits each word into two byte writes, high byte first, into a byte-wide frame RAM. Byte order matches the read side: a word read at address a equals {mem[a], mem[a+1]}. The block sits between the processing pipeline output and the frame RAM write port.

Parameters:
DEPTH, 307200, frame size in bytes; must be even and >= 2
ADDR_W, 19, RAM address width; 2^ADDR_W >= DEPTH
DATA_W, 16, input word width; fixed at 2 bytes

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request to begin a frame; sampled only in IDLE
abort  in  1  synchronous cancel of the current frame
s_valid  in  1  input word valid
s_data  in  16  input pixel word; [15:8] written first
s_ready  out  1  block accepts s_data this cycle; equals (state==LOAD)
mem_we  out  1  RAM write enable, registered
mem_addr  out  ADDR_W  RAM byte address, registered
mem_wdata  out  8  RAM write data, registered
busy  out  1  high while a frame is in progress (state != IDLE)
done  out  1  one-cycle pulse after the final byte write

Behaviour:
- Reset (async, rst_n=0) values:
  - state=IDLE
  - mem_we=0, mem_addr=0, mem_wdata=0
  - done=0, busy=0, s_ready=0
  - internal addr counter=0, lo_hold=0
- States:
  - IDLE: s_ready=0. If start=1, go to LOAD and clear the address counter to 0.
  - LOAD: s_ready=1. When s_valid=1, the word is accepted on that edge.
    - Next cycle: mem_we=1, mem_addr=cnt, mem_wdata=s_data[15:8].
    - lo_hold<=s_data[7:0]; go to LOW.
    - If s_valid=0: mem_we=0 next cycle; stay in LOAD.
  - LOW: s_ready=0. Next cycle: mem_we=1, mem_addr=cnt+1, mem_wdata=lo_hold.
    - If cnt+1 == DEPTH-1, go to FIN.
    - Otherwise cnt<=cnt+2 and go to LOAD.
  - FIN: next cycle mem_we=0 and done=1 for exactly one cycle; go to IDLE.
- Latency: word accepted at edge k gives high-byte write in cycle k+1 and low-byte write in cycle k+2.
- Throughput: s_ready is re-asserted in cycle k+2, giving a peak rate of 1 word per 2 clocks.
- busy is registered:
  - rises the cycle after start is accepted;
  - falls in the same cycle done is high.
- start while busy is ignored (no restart, no counter clear).
- abort=1 in any non-IDLE state:
  - next edge: state=IDLE, mem_we=0, done=0, busy=0;
  - any half-written word is dropped;
  - abort has priority over s_valid and over the LOW/FIN transitions.
- abort and start asserted together in IDLE: abort wins, stay IDLE.
- Address width rules:
  - counter is ADDR_W bits and never exceeds DEPTH-1;
  - no wrap-around inside a frame;
  - each new frame restarts at 0.
- No RAM write is issued outside LOAD-accept / LOW, so mem_we=0 in IDLE and FIN.
- Reset mid-frame: all outputs return to reset values immediately (asynchronously). The RAM contents already written are left as-is.

Test Plan:
- Sim with DEPTH=8. Pulse start, then stream words 0x1122, 0x3344, 0x5566, 0x7788 with s_valid held high -> byte writes (addr:data) 0:11, 1:22, 2:33, 3:44, 4:55, 5:66, 6:77, 7:88 on consecutive cycles. s_ready toggles 1,0. done is high one cycle after the write to addr 7. busy then goes low.
- Gapped valid: s_valid low for 3 cycles between words -> s_ready stays 1 and mem_we stays 0 during the gap. Addresses resume without skips and the byte sequence is identical to the first test.
- Abort after the high byte of word 2 (addr 2 written) -> no write to addr 3, done never pulses, busy=0 next cycle. A new start then writes from addr 0 again.
- start pulsed mid-frame at word 3 -> ignored. The frame completes at addr 7 with a single done pulse.
- Assert rst_n=0 asynchronously during LOW -> mem_we, done, busy and s_ready drop to 0 without waiting for a clock edge. After release, the block is IDLE and ignores s_valid until start.
- Full size DEPTH=307200 with an incrementing word pattern -> the last write is at addr 307199, done is asserted once, and the counter never reaches 307200.

Source files
------------

// File: rtl/frame_writer.sv
// Streams 16-bit pixel words into a byte-wide frame RAM, high byte first.
// Each accepted word becomes two consecutive registered byte writes.
module frame_writer #(
    parameter int DEPTH  = 307200,
    parameter int ADDR_W = 19,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, LOAD, LOW, FIN} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] cnt, cnt_nx, addr_nx, cnt_inc;
    logic [7:0]        lo_hold, lo_nx, wdata_nx;
    logic              we_nx, done_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            lo_hold   <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            lo_hold   <= lo_nx;
            mem_we    <= we_nx;
            mem_addr  <= addr_nx;
            mem_wdata <= wdata_nx;
            done      <= done_nx;
            busy      <= (state_nx != IDLE);
        end
    end

    assign s_ready = (state == LOAD);
    assign cnt_inc = cnt + ADDR_W'(1);

    // abort is tested first in every busy state so it overrides accept and the LOW/FIN moves
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        lo_nx    = lo_hold;
        we_nx    = 1'b0;
        addr_nx  = mem_addr;
        wdata_nx = mem_wdata;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nx = LOAD;
                    cnt_nx   = '0;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (s_valid) begin
                    we_nx    = 1'b1;
                    addr_nx  = cnt;
                    wdata_nx = s_data[15:8];
                    lo_nx    = s_data[7:0];
                    state_nx = LOW;
                end
            end
            LOW: begin
                if (abort) begin
                    state_nx = IDLE;
                end else begin
                    we_nx    = 1'b1;
                    addr_nx  = cnt_inc;
                    wdata_nx = lo_hold;
                    if (cnt_inc == LAST) begin
                        state_nx = FIN;
                    end else begin
                        cnt_nx   = cnt + ADDR_W'(2);
                        state_nx = LOAD;
                    end
                end
            end
            FIN: begin
                state_nx = IDLE;
                done_nx  = !abort;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_frame_writer.sv
// Bench for frame_writer on an 8-byte frame: directed scenarios plus random
// frames checked against a byte-stream model of the expected RAM writes.
module tb_frame_writer;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;
    localparam int NW     = DEPTH / 2;

    logic              clk = 1'b0;
    logic              rst_n, start, abort, s_valid;
    logic [15:0]       s_data;
    logic              s_ready, mem_we, busy, done;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;

    int checks = 0;
    int errors = 0;

    logic [15:0] words [NW];
    int          gaps  [NW];

    logic [ADDR_W-1:0] got_addr [$];
    logic [7:0]        got_data [$];
    int                got_cyc  [$];
    int                cyc      = 0;
    int                done_cnt = 0;

    frame_writer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mem_we) begin
            got_addr.push_back(mem_addr);
            got_data.push_back(mem_wdata);
            got_cyc.push_back(cyc);
        end
        if (done) done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Expected byte stream: byte k of the frame is the high byte of word k/2 for even k, low byte otherwise.
    task automatic compare_writes(input int base, input int n_exp);
        int n_got;
        logic [7:0] eb;
        n_got = got_addr.size() - base;
        check("wr_count", 32'(n_got), 32'(n_exp));
        for (int k = 0; k < n_exp && k < n_got; k++) begin
            eb = (k % 2 == 0) ? words[k / 2][15:8] : words[k / 2][7:0];
            check($sformatf("wr_addr[%0d]", k), 32'(got_addr[base + k]), 32'(k));
            check($sformatf("wr_data[%0d]", k), 32'(got_data[base + k]), 32'(eb));
        end
    endtask

    task automatic run_frame(input int abort_at, input bit start_mid);
        int base, dbase;
        bit no_gaps;
        base    = got_addr.size();
        dbase   = done_cnt;
        no_gaps = 1'b1;
        for (int i = 0; i < NW; i++) if (gaps[i] != 0) no_gaps = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("ready_after_start", 32'(s_ready), 32'd1);
        for (int i = 0; i < NW; i++) begin
            s_data = words[i];
            if (gaps[i] > 0) begin
                s_valid = 1'b0;
                for (int g = 0; g < gaps[i]; g++) begin
                    step();
                    check("gap_ready", 32'(s_ready), 32'd1);
                    check("gap_we", 32'(mem_we), 32'd0);
                end
            end
            s_valid = 1'b1;
            if (start_mid && i == 2) start = 1'b1;
            step();
            start = 1'b0;
            if (abort_at == i) abort = 1'b1;
            if (i < NW - 1) begin
                s_data  = words[i + 1];
                s_valid = (gaps[i + 1] == 0);
            end else begin
                s_valid = 1'b0;
            end
            check("hi_we", 32'(mem_we), 32'd1);
            check("hi_addr", 32'(mem_addr), 32'(2 * i));
            check("hi_data", 32'(mem_wdata), 32'(words[i][15:8]));
            check("hi_ready", 32'(s_ready), 32'd0);
            check("hi_busy", 32'(busy), 32'd1);
            step();
            if (abort_at == i) begin
                abort = 1'b0;
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_we", 32'(mem_we), 32'd0);
                check("abort_ready", 32'(s_ready), 32'd0);
                check("abort_done", 32'(done), 32'd0);
                s_valid = 1'b1;
                for (int g = 0; g < 3; g++) begin
                    step();
                    check("post_abort_ready", 32'(s_ready), 32'd0);
                    check("post_abort_busy", 32'(busy), 32'd0);
                end
                s_valid = 1'b0;
                step();
                compare_writes(base, 2 * i + 1);
                check("abort_done_count", 32'(done_cnt - dbase), 32'd0);
                return;
            end
            check("lo_we", 32'(mem_we), 32'd1);
            check("lo_addr", 32'(mem_addr), 32'(2 * i + 1));
            check("lo_data", 32'(mem_wdata), 32'(words[i][7:0]));
            check("lo_ready", 32'(s_ready), (i < NW - 1) ? 32'd1 : 32'd0);
        end
        s_valid = 1'b0;
        step();
        check("done_pulse", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        check("done_we", 32'(mem_we), 32'd0);
        check("done_ready", 32'(s_ready), 32'd0);
        step();
        check("done_width", 32'(done), 32'd0);
        compare_writes(base, DEPTH);
        check("done_count", 32'(done_cnt - dbase), 32'd1);
        if (no_gaps && got_addr.size() - base == DEPTH)
            check("consecutive", 32'(got_cyc[base + DEPTH - 1] - got_cyc[base]), 32'(DEPTH - 1));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
        #12;
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(s_ready), 32'd0);
        step();
        rst_n = 1'b1;

        // valid without start is ignored
        s_valid = 1'b1; s_data = 16'hABCD;
        step();
        step();
        check("idle_ready", 32'(s_ready), 32'd0);
        check("idle_we", 32'(mem_we), 32'd0);
        s_valid = 1'b0;

        // abort beats start in IDLE
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        check("abort_start_busy", 32'(busy), 32'd0);
        check("abort_start_ready", 32'(s_ready), 32'd0);
        step();

        words[0] = 16'h1122; words[1] = 16'h3344; words[2] = 16'h5566; words[3] = 16'h7788;
        for (int i = 0; i < NW; i++) gaps[i] = 0;
        run_frame(-1, 1'b0);
        for (int i = 0; i < NW; i++) gaps[i] = 3;
        run_frame(-1, 1'b0);
        for (int i = 0; i < NW; i++) gaps[i] = 0;
        run_frame(1, 1'b0);
        run_frame(-1, 1'b0);
        run_frame(-1, 1'b1);

        // asynchronous reset while the low byte is pending
        start = 1'b1;
        step();
        start = 1'b0;
        s_valid = 1'b1; s_data = 16'hC3A5;
        step();
        check("pre_rst_we", 32'(mem_we), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check("async_we", 32'(mem_we), 32'd0);
        check("async_done", 32'(done), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_ready", 32'(s_ready), 32'd0);
        check("async_addr", 32'(mem_addr), 32'd0);
        #2 rst_n = 1'b1;
        for (int g = 0; g < 3; g++) begin
            step();
            check("post_rst_ready", 32'(s_ready), 32'd0);
            check("post_rst_we", 32'(mem_we), 32'd0);
            check("post_rst_busy", 32'(busy), 32'd0);
        end
        s_valid = 1'b0;

        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < NW; i++) begin
                words[i] = 16'($urandom);
                gaps[i]  = $urandom_range(0, 3);
            end
            run_frame(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NW - 1)) : -1,
                      1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
